scan_display_ctrl: RTL and testbench

- Time-multiplexed driver for the 8-digit seven-segment display of the clock.
- Divides the system clock into digit slots and sequences a 3-bit digit index 0..7 that wraps.
- Drives active-low anode enables with dead time between digits, and selects the BCD nibble and decimal point for the active digit.
- Supports per-digit blanking, and per-digit blinking for time-set mode.

---
 rtl/scan_display_ctrl.sv | 96 +++++++++
 tb/tb_scan_display_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - time-multiplexed 8-digit seven-segment scan driver
module scan_display_ctrl #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int BLINK_DIV   = 64
) (
    input  logic        CP,
    input  logic        reset,
    input  logic        EN,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  an,
    output logic [3:0]  seg_code,
    output logic        seg_dp,
    output logic [2:0]  digit_sel,
    output logic        scan_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIMIT = CW'(DEAD_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_digit;
    logic [FW-1:0] r_frame;
    logic          r_blink_phase;
    logic [7:0]    r_an;
    logic [3:0]    r_seg_code;
    logic          r_seg_dp;
    logic          r_scan_tick;

    logic          w_slot_last;
    logic          w_show;
    logic          w_suppress;
    logic [4:0]    w_nibble_base;

    assign w_slot_last   = (r_cnt == CNT_LAST);
    assign w_show        = (r_cnt >= DEAD_LIMIT);
    assign w_suppress    = blank_mask[r_digit] | (blink_mask[r_digit] & r_blink_phase);
    assign w_nibble_base = {r_digit, 2'b00};

    // Slot counter, digit index, frame counter and blink phase; all frozen while EN is low.
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_digit       <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else if (EN) begin
            if (w_slot_last) begin
                r_cnt   <= '0;
                r_digit <= r_digit + 3'd1;
                if (r_digit == 3'd7) begin
                    if (r_frame == FRAME_LAST) begin
                        r_frame       <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_frame <= r_frame + FW'(1);
                    end
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Registered display outputs, one cycle behind the slot position that produced them.
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            r_an        <= 8'hFF;
            r_seg_code  <= 4'h0;
            r_seg_dp    <= 1'b0;
            r_scan_tick <= 1'b0;
        end else begin
            r_seg_code  <= digits[w_nibble_base +: 4];
            r_seg_dp    <= dp[r_digit];
            r_scan_tick <= EN & w_slot_last;
            if (EN && w_show && !w_suppress) begin
                r_an <= ~(8'h01 << r_digit);
            end else begin
                r_an <= 8'hFF;
            end
        end
    end

    assign an        = r_an;
    assign seg_code  = r_seg_code;
    assign seg_dp    = r_seg_dp;
    assign digit_sel = r_digit;
    assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb/tb_scan_display_ctrl.sv - self-checking bench for scan_display_ctrl
module tb_scan_display_ctrl;

    logic        CP;
    logic        reset;
    logic        EN;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [3:0]  seg_code;
    logic        seg_dp;
    logic [2:0]  digit_sel;
    logic        scan_tick;

    int n_pass;
    int n_total;

    typedef struct {
        logic [2:0] d;
        logic [7:0] an;
        logic [3:0] seg;
        logic       sdp;
        logic       tick;
    } vec_t;

    vec_t vtab[40];

    scan_display_ctrl #(
        .SCAN_DIV   (4),
        .DEAD_CYCLES(1),
        .BLINK_DIV  (2)
    ) dut (
        .CP        (CP),
        .reset     (reset),
        .EN        (EN),
        .digits    (digits),
        .dp        (dp),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .an        (an),
        .seg_code  (seg_code),
        .seg_dp    (seg_dp),
        .digit_sel (digit_sel),
        .scan_tick (scan_tick)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        EN         = 1'b0;
        blank_mask = 8'h00;
        blink_mask = 8'h00;
        repeat (2) step();
        reset = 1'b1;
    endtask

    function automatic logic [7:0] exp_an(input int j, input logic [7:0] bmask, input logic phase_blinked,
                                          input logic [7:0] kmask);
        int c;
        int d;
        c = j % 4;
        d = (j / 4) % 8;
        if (c == 0 || bmask[d] || (kmask[d] && phase_blinked)) return 8'hFF;
        return ~(8'h01 << d);
    endfunction

    initial begin
        int cnt7f [3];
        int n_fe;
        n_pass     = 0;
        n_total    = 0;
        digits     = 32'h76543210;
        dp         = 8'h04;

        // Expected outputs after edge k (1-based), from the slot position j = k-1 before the edge.
        for (int k = 1; k <= 40; k++) begin
            int j;
            j = k - 1;
            vtab[k-1].d    = 3'((k / 4) % 8);
            vtab[k-1].tick = (k % 4 == 0);
            vtab[k-1].an   = (j % 4 == 0) ? 8'hFF : ~(8'h01 << ((j / 4) % 8));
            vtab[k-1].seg  = 4'((j / 4) % 8);
            vtab[k-1].sdp  = (((j / 4) % 8) == 2);
        end

        // Reset state
        do_reset();
        chk("reset_an", 32'(an), 32'hFF);
        chk("reset_digit", 32'(digit_sel), 32'h0);
        chk("reset_seg", 32'({seg_code, seg_dp, scan_tick}), 32'h0);

        // Free-running scan over 40 cycles
        EN = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("scan_k%0d", k),
                32'({digit_sel, an, seg_code, seg_dp, scan_tick}),
                32'({vtab[k-1].d, vtab[k-1].an, vtab[k-1].seg, vtab[k-1].sdp, vtab[k-1].tick}));
        end

        // EN drop during digit 3 SHOW, cnt=2
        do_reset();
        EN = 1'b1;
        repeat (14) step();
        chk("pre_drop_digit", 32'(digit_sel), 32'd3);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("en_off_%0d", i), 32'({digit_sel, an, scan_tick}), 32'({3'd3, 8'hFF, 1'b0}));
        end
        EN = 1'b1;
        step();
        chk("resume_0", 32'({digit_sel, an, scan_tick}), 32'({3'd3, 8'hF7, 1'b0}));
        step();
        chk("resume_1", 32'({digit_sel, an, scan_tick}), 32'({3'd4, 8'hF7, 1'b1}));
        step();
        chk("resume_2", 32'({digit_sel, an, scan_tick}), 32'({3'd4, 8'hFF, 1'b0}));
        step();
        chk("resume_3", 32'({digit_sel, an, scan_tick}), 32'({3'd4, 8'hEF, 1'b0}));

        // Blanking digit 0 over 2 frames
        do_reset();
        blank_mask = 8'h01;
        EN         = 1'b1;
        n_fe       = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (an == 8'hFE) n_fe++;
            chk($sformatf("blank_k%0d", k), 32'(an), 32'(exp_an(k - 1, 8'h01, 1'b0, 8'h00)));
        end
        chk("blank_no_fe", 32'(n_fe), 32'd0);

        // Blinking digit 7 over 6 frames
        do_reset();
        blink_mask = 8'h80;
        EN         = 1'b1;
        for (int g = 0; g < 3; g++) cnt7f[g] = 0;
        for (int k = 1; k <= 192; k++) begin
            step();
            if (an == 8'h7F) cnt7f[(k - 1) / 64]++;
        end
        chk("blink_f01", 32'(cnt7f[0]), 32'd6);
        chk("blink_f23", 32'(cnt7f[1]), 32'd0);
        chk("blink_f45", 32'(cnt7f[2]), 32'd6);

        // Asynchronous reset mid-slot, right after a tick
        do_reset();
        EN = 1'b1;
        repeat (16) step();
        chk("pre_rst_state", 32'({digit_sel, an, scan_tick}), 32'({3'd4, 8'hF7, 1'b1}));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", 32'({digit_sel, an, seg_code, seg_dp, scan_tick}), 32'({3'd0, 8'hFF, 4'h0, 1'b0, 1'b0}));
        step();
        reset = 1'b1;
        step();
        chk("post_rst_0", 32'({digit_sel, an, seg_code}), 32'({3'd0, 8'hFF, 4'h0}));
        step();
        chk("post_rst_1", 32'({digit_sel, an, seg_code}), 32'({3'd0, 8'hFE, 4'h0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // An must never have more than one active-low bit.
    always @(negedge CP) begin
        if (reset && $countones(~an) > 1) begin
            n_total++;
            $display("FAIL one_hot_an: got %h expected at most one low bit", an);
        end
    end

endmodule
